// File: rtl/serial_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the nibble-serial add/subtract sequencer.
package serial_add_sequencer_pkg;

  localparam int NIB_W = 4;

  // 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_RSVD = 2'd3
  } state_e;

endpackage

// File: rtl/four_bit_adder.sv
// Gate-level 4-bit ripple-carry adder; the only arithmetic in the sequencer.
module four_bit_adder
  import serial_add_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/serial_add_sequencer.sv
// WIDTH-bit add/subtract processed one nibble per clock, LSB first, through a
// single shared four_bit_adder; valid/ready on both request and result sides.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e state_q, state_d;

  // Operands and result viewed as nibble arrays so idx selects a lane directly.
  logic [NIB-1:0][NIB_W-1:0] a_q, a_d;
  logic [NIB-1:0][NIB_W-1:0] b_q, b_d;
  logic [NIB-1:0][NIB_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_cout;

  assign nib_a = a_q[idx_q];
  assign nib_b = b_q[idx_q];

  four_bit_adder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_RSVD);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_RUN: begin
        res_d[idx_q] = nib_sum;
        carry_d      = nib_cout;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          cout_d  = nib_cout;
          // Operands share a sign but the result's sign differs.
          ovf_d   = (nib_a[NIB_W-1] == nib_b[NIB_W-1]) &&
                    (nib_sum[NIB_W-1] != nib_a[NIB_W-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B once here, inject the +1 as carry-in.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer against an arithmetic model.
module tb_serial_add_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] r,
                                output logic c, output logic o);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b;
      c  = ((int'(a) + int'(b)) >= (1 << W));
      sr = sa + sb;
    end
    o = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
  endfunction

  // Issue one request, wait for the result; retires it if out_ready is high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic o,
                       output int lat, output bit to);
    int n;
    to = 0;
    n  = 0;
    @(negedge clk);
    a_i = a; b_i = b; sub_i = s; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) to = 1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) to = 1;
    r = result; c = cout; o = overflow;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
    logic [W-1:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0005};
    logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] er [6] = '{16'h5555, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0002};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] r;
    logic c, o;
    int lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vs[i], r, c, o, lat, to);
      checks++; if (to || lat != NIB) begin errors++; $display("FAIL dir%0d_latency got %0d (timeout %0d) want %0d", i, lat, to, NIB); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, r, er[i]); end
      checks++; if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, c, ec[i]); end
      checks++; if (o !== eo[i]) begin errors++; $display("FAIL dir%0d_overflow got %b want %b", i, o, eo[i]); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r, er;
    logic s, c, o, ec, eo;
    int lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      if (i % 5 == 0) b = a;
      model(a, b, s, er, ec, eo);
      do_op(a, b, s, r, c, o, lat, to);
      checks++;
      if (to || r !== er || c !== ec || o !== eo) begin
        errors++;
        $display("FAIL rnd%0d %h %s %h got r=%h c=%b o=%b to=%0d want r=%h c=%b o=%b",
                 i, a, s ? "-" : "+", b, r, c, o, to, er, ec, eo);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] r, er;
    logic c, o, ec, eo;
    int lat;
    bit to;
    out_ready = 1'b0;
    model(16'h0F0F, 16'h00F1, 1'b0, er, ec, eo);
    do_op(16'h0F0F, 16'h00F1, 1'b0, r, c, o, lat, to);
    checks++; if (to || r !== er) begin errors++; $display("FAIL bp_result got %h want %h", r, er); end
    for (int i = 0; i < 5; i++) begin
      a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
      in_valid = 1'(i % 2 == 0);
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== er) begin
        errors++;
        $display("FAIL bp_hold%0d in_ready=%b out_valid=%b result=%h want 0,1,%h",
                 i, in_ready, out_valid, result, er);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== er) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b result=%h want 1,0,%h",
               in_ready, out_valid, result, er);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [W-1:0] r;
    logic c, o;
    int lat;
    bit to, seen;
    out_ready = 1'b1;
    @(negedge clk);
    a_i = 16'h1111; b_i = 16'h2222; sub_i = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid out_valid=%b in_ready=%b result=%h cout=%b ovf=%b want 0,1,0000,0,0",
               out_valid, in_ready, result, cout, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_no_out_valid got pulse want none"); end
    do_op(16'h0001, 16'h0001, 1'b0, r, c, o, lat, to);
    checks++; if (to || r !== 16'h0002) begin errors++; $display("FAIL rst_follow_result got %h want 0002", r); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qr[$];
    logic         qc[$], qo[$];
    int           acc_cyc[$];
    logic [W-1:0] er;
    logic         ec, eo, acc;
    int           cyc, n_acc, n_done;
    cyc = 0; n_acc = 0; n_done = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom); in_valid = 1'b1;
    while (n_done < 3 && cyc < 100) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (acc) begin
        model(a_i, b_i, sub_i, er, ec, eo);
        qr.push_back(er); qc.push_back(ec); qo.push_back(eo);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
        else begin a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom); end
      end
      if (out_valid && qr.size() > 0) begin
        er = qr.pop_front(); ec = qc.pop_front(); eo = qo.pop_front();
        checks++;
        if (result !== er || cout !== ec || overflow !== eo) begin
          errors++;
          $display("FAIL b2b%0d got r=%h c=%b o=%b want r=%h c=%b o=%b",
                   n_done, result, cout, overflow, er, ec, eo);
        end
        n_done++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_done != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_done); end
    if (acc_cyc.size() == 3) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != NIB + 2) begin errors++; $display("FAIL b2b_interval0 got %0d want %0d", acc_cyc[1] - acc_cyc[0], NIB + 2); end
      checks++; if (acc_cyc[2] - acc_cyc[1] != NIB + 2) begin errors++; $display("FAIL b2b_interval1 got %0d want %0d", acc_cyc[2] - acc_cyc[1], NIB + 2); end
    end else begin
      checks++; errors++; $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size());
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
